// File: rtl/mem_access_pkg.sv
// Shared definitions for the load/store access unit: size encodings and FSM states.
package mem_access_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/mem_access_check.sv
// Combinational legality check for a load/store request.
// Defining MISALIGN_TRAP_EN additionally rejects misaligned half/word accesses.
module mem_access_check
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 9
) (
    input  logic              write,
    input  logic [1:0]        size,
    input  logic [ADDR_W-1:0] address,
    output logic              illegal
);

    logic [1:0]      extra;
    logic [ADDR_W:0] last_byte;
    logic            misaligned;

    // A carry out of the last byte address means the access wraps past the top of memory.
    always_comb begin
        extra = 2'd3;
        case (size)
            SZ_BYTE: extra = 2'd0;
            SZ_HALF: extra = 2'd1;
            default: extra = 2'd3;
        endcase
        last_byte  = {1'b0, address} + {{(ADDR_W - 1){1'b0}}, extra};
        misaligned = 1'b0;
`ifdef MISALIGN_TRAP_EN
        if (size == SZ_HALF) begin
            misaligned = address[0];
        end else if (size != SZ_BYTE) begin
            misaligned = |address[1:0];
        end
`else
        misaligned = 1'b0;
`endif
        illegal = (write && (size == SZ_RSVD)) || last_byte[ADDR_W] || misaligned;
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store access unit: accepts one CPU request, issues a single memory cycle, holds the response.
// Optional build macro MISALIGN_TRAP_EN (see mem_access_check) turns misaligned accesses into errors.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              ReqValid,
    output logic              ReqReady,
    input  logic              ReqWrite,
    input  logic [1:0]        ReqSize,
    input  logic              ReqSE,
    input  logic [ADDR_W-1:0] ReqAddr,
    input  logic [DATA_W-1:0] ReqData,
    output logic              RespValid,
    input  logic              RespReady,
    output logic [DATA_W-1:0] RespData,
    output logic              RespErr,
    output logic              MemEnable,
    output logic              MemReadWrite,
    output logic              MemSE,
    output logic [1:0]        MemSize,
    output logic [ADDR_W-1:0] MemAddress,
    output logic [DATA_W-1:0] MemDataIn,
    input  logic [DATA_W-1:0] MemDataOut
);

    state_t            state, state_next;
    logic              pending;
    logic              armed;
    logic              accept;
    logic              illegal;
    logic              access;
    logic              r_write;
    logic [1:0]        r_size;
    logic              r_se;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] resp_data;
    logic              resp_err;

    // The check runs on the registered request, one cycle after acceptance.
    mem_access_check #(.ADDR_W(ADDR_W)) u_check (
        .write   (r_write),
        .size    (r_size),
        .address (r_addr),
        .illegal (illegal)
    );

    assign ReqReady = armed && (state == IDLE) && !pending;
    assign accept   = ReqValid && ReqReady;
    assign access   = (state == ACCESS);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pending) state_next = illegal ? RESP : ACCESS;
            ACCESS:  state_next = RESP;
            RESP:    if (RespReady) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            pending   <= 1'b0;
            armed     <= 1'b0;
            r_write   <= 1'b0;
            r_size    <= 2'b00;
            r_se      <= 1'b0;
            r_addr    <= '0;
            r_data    <= '0;
            resp_data <= '0;
            resp_err  <= 1'b0;
        end else begin
            state   <= state_next;
            armed   <= 1'b1;
            pending <= accept;
            if (accept) begin
                r_write <= ReqWrite;
                r_size  <= ReqSize;
                r_se    <= ReqSE;
                r_addr  <= ReqAddr;
                r_data  <= ReqData;
            end
            if ((state == IDLE) && pending && illegal) begin
                resp_data <= '0;
                resp_err  <= 1'b1;
            end
            if (state == ACCESS) begin
                resp_data <= r_write ? '0 : MemDataOut;
                resp_err  <= 1'b0;
            end
        end
    end

    // Memory-side outputs are forced to zero outside the single access cycle.
    assign MemEnable    = access;
    assign MemReadWrite = access && r_write;
    assign MemSE        = access && r_se;
    assign MemSize      = access ? r_size : 2'b00;
    assign MemAddress   = access ? r_addr : '0;
    assign MemDataIn    = access ? r_data : '0;

    assign RespValid = (state == RESP);
    assign RespData  = resp_data;
    assign RespErr   = resp_err;

endmodule
